// File: rtl/cordic_sched_pkg.sv
// Shared constants and helpers for the CORDIC scheduler and its CORDIC instantiation.
package cordic_sched_pkg;

    localparam int unsigned CORDIC_XY_BITS = 12;
    localparam int unsigned CORDIC_PH_BITS = 32;
    localparam int unsigned CORDIC_LATENCY = 34;

    // Tag-entry field widths: one valid bit plus a requester id of up to 3 bits (8 requesters).
    localparam int unsigned TAG_VALID_W  = 1;
    localparam int unsigned TAG_ID_MAX_W = 3;

    // Ceiling log2, never less than 1 so single-bit ids stay legal.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/cordic_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the requester after the last grantee.
module rr_arbiter
    import cordic_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W = clog2(NUM_REQ)
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic               update,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    logic [ID_W-1:0] last;
    logic [ID_W-1:0] cand;
    logic            found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(last) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found    = 1'b1;
                grant_id = cand;
            end
        end
        if (found && en) grant[grant_id] = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            last <= ID_W'(NUM_REQ - 1);
        end else if (update) begin
            last <= grant_id;
        end
    end

endmodule

// File: rtl/cordic_sched.sv
// Shares one fixed-latency CORDIC among NUM_REQ requesters, tagging jobs and routing results back.
module cordic_sched
    import cordic_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned XY_BITS = CORDIC_XY_BITS,
    parameter int unsigned PH_BITS = CORDIC_PH_BITS,
    parameter int unsigned LATENCY = CORDIC_LATENCY
) (
    input  logic                       clk_in,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*XY_BITS-1:0] req_x,
    input  logic [NUM_REQ*XY_BITS-1:0] req_y,
    input  logic [NUM_REQ*PH_BITS-1:0] req_phase,
    output logic                       cor_valid_in,
    output logic [XY_BITS-1:0]         cor_x_i,
    output logic [XY_BITS-1:0]         cor_y_i,
    output logic [PH_BITS-1:0]         cor_phase_in,
    input  logic                       cor_valid_out,
    input  logic [XY_BITS-1:0]         cor_x_o,
    input  logic [XY_BITS-1:0]         cor_y_o,
    input  logic [PH_BITS-1:0]         cor_phase_out,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [XY_BITS-1:0]         rsp_x,
    output logic [XY_BITS-1:0]         rsp_y,
    output logic [PH_BITS-1:0]         rsp_phase,
    output logic                       busy,
    output logic                       err
);

    localparam int unsigned ID_W = clog2(NUM_REQ);
    localparam int unsigned DR_W = clog2(LATENCY + 1);

    logic [ID_W-1:0]              grant_id;
    logic                         hs;
    logic [ID_W-1:0]              cor_id;
    logic [LATENCY-1:0]           tag_v;
    logic [LATENCY-1:0][ID_W-1:0] tag_id;
    logic                         tail_v;
    logic [ID_W-1:0]              tail_id;
    logic [DR_W-1:0]              drain_cnt;
    logic                         mismatch;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .req      (req_valid),
        .en       (en & rst_n),
        .update   (hs),
        .grant    (req_ready),
        .grant_id (grant_id)
    );

    assign hs       = |(req_valid & req_ready);
    assign tail_v   = tag_v[LATENCY-1];
    assign tail_id  = tag_id[LATENCY-1];
    assign mismatch = (cor_valid_out != tail_v) && (drain_cnt == '0);
    assign busy     = cor_valid_in | (|tag_v);

    // The issue register is the pipe's first stage, so the tail sits LATENCY cycles behind cor_valid_in.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cor_valid_in <= 1'b0;
            cor_id       <= '0;
            cor_x_i      <= '0;
            cor_y_i      <= '0;
            cor_phase_in <= '0;
            tag_v        <= '0;
            tag_id       <= '0;
        end else begin
            cor_valid_in <= hs;
            tag_v        <= {tag_v[LATENCY-2:0], cor_valid_in};
            tag_id       <= {tag_id[LATENCY-2:0], cor_id};
            if (hs) begin
                cor_id       <= grant_id;
                cor_x_i      <= req_x[32'(grant_id) * XY_BITS +: XY_BITS];
                cor_y_i      <= req_y[32'(grant_id) * XY_BITS +: XY_BITS];
                cor_phase_in <= req_phase[32'(grant_id) * PH_BITS +: PH_BITS];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_x     <= '0;
            rsp_y     <= '0;
            rsp_phase <= '0;
            err       <= 1'b0;
            drain_cnt <= DR_W'(LATENCY);
        end else begin
            rsp_valid <= '0;
            if (cor_valid_out && tail_v) begin
                rsp_valid[tail_id] <= 1'b1;
                rsp_x              <= cor_x_o;
                rsp_y              <= cor_y_o;
                rsp_phase          <= cor_phase_out;
            end
            if (mismatch) err <= 1'b1;
            if (drain_cnt != '0) drain_cnt <= drain_cnt - DR_W'(1);
        end
    end

endmodule

// File: tb/tb_cordic_sched.sv
// Directed bench for cordic_sched with a fixed-latency CORDIC model (x+1, y-1, phase+1).
module tb_cordic_sched;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [47:0] req_x;
    logic [47:0] req_y;
    logic [127:0] req_phase;
    logic        cor_valid_in;
    logic [11:0] cor_x_i;
    logic [11:0] cor_y_i;
    logic [31:0] cor_phase_in;
    logic        cor_valid_out;
    logic [11:0] cor_x_o;
    logic [11:0] cor_y_o;
    logic [31:0] cor_phase_out;
    logic [3:0]  rsp_valid;
    logic [11:0] rsp_x;
    logic [11:0] rsp_y;
    logic [31:0] rsp_phase;
    logic        busy;
    logic        err;

    int tests;
    int fails;

    // CORDIC model: taps chosen so output appears tap+1 cycles after cor_valid_in.
    logic [5:0]  tap;
    logic        inj;
    logic        mv [64];
    logic [11:0] mx [64];
    logic [11:0] my [64];
    logic [31:0] mp [64];

    cordic_sched #(
        .NUM_REQ (4),
        .XY_BITS (12),
        .PH_BITS (32),
        .LATENCY (34)
    ) dut (
        .clk_in        (clk),
        .rst_n         (rst_n),
        .en            (en),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_x         (req_x),
        .req_y         (req_y),
        .req_phase     (req_phase),
        .cor_valid_in  (cor_valid_in),
        .cor_x_i       (cor_x_i),
        .cor_y_i       (cor_y_i),
        .cor_phase_in  (cor_phase_in),
        .cor_valid_out (cor_valid_out),
        .cor_x_o       (cor_x_o),
        .cor_y_o       (cor_y_o),
        .cor_phase_out (cor_phase_out),
        .rsp_valid     (rsp_valid),
        .rsp_x         (rsp_x),
        .rsp_y         (rsp_y),
        .rsp_phase     (rsp_phase),
        .busy          (busy),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        mv[0] <= cor_valid_in;
        mx[0] <= cor_x_i + 12'd1;
        my[0] <= cor_y_i - 12'd1;
        mp[0] <= cor_phase_in + 32'd1;
        for (int k = 1; k < 64; k++) begin
            mv[6'(k)] <= mv[6'(k - 1)];
            mx[6'(k)] <= mx[6'(k - 1)];
            my[6'(k)] <= my[6'(k - 1)];
            mp[6'(k)] <= mp[6'(k - 1)];
        end
    end

    assign cor_valid_out = mv[tap] | inj;
    assign cor_x_o       = mx[tap];
    assign cor_y_o       = my[tap];
    assign cor_phase_out = mp[tap];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [11:0] x, input logic [11:0] y, input logic [31:0] p);
        req_x[i*12 +: 12]     = x;
        req_y[i*12 +: 12]     = y;
        req_phase[i*32 +: 32] = p;
    endtask

    task automatic wait_rsp(input int maxc, output int n);
        n = 0;
        while (rsp_valid == 4'b0000 && n < maxc) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
    endtask

    initial begin
        int n;
        logic bad;
        tests = 0;
        fails = 0;
        for (int k = 0; k < 64; k++) begin
            mv[6'(k)] = 1'b0;
            mx[6'(k)] = '0;
            my[6'(k)] = '0;
            mp[6'(k)] = '0;
        end
        tap       = 6'd33;
        inj       = 1'b0;
        rst_n     = 1'b0;
        en        = 1'b1;
        req_valid = 4'hF;
        req_x     = '0;
        req_y     = '0;
        req_phase = '0;

        // Reset values
        repeat (3) tick();
        #1;
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_cvin", cor_valid_in, 1'b0);
        chk("rst_cx", cor_x_i, 12'd0);
        chk("rst_rspv", rsp_valid, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        req_valid = 4'h0;
        rst_n     = 1'b1;
        tick();

        // Single job from requester 0
        set_op(0, 12'd100, 12'd0, 32'h4000_0000);
        req_valid = 4'b0001;
        #1;
        chk("single_ready", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0000;
        chk("single_cvin", cor_valid_in, 1'b1);
        chk("single_cx", cor_x_i, 12'd100);
        chk("single_cy", cor_y_i, 12'd0);
        chk("single_cph", cor_phase_in, 32'h4000_0000);
        wait_rsp(60, n);
        chk("single_lat", n, 35);
        chk("single_rspv", rsp_valid, 4'b0001);
        chk("single_rx", rsp_x, 12'd101);
        chk("single_ry", rsp_y, 12'hFFF);
        chk("single_rph", rsp_phase, 32'h4000_0001);
        chk("single_err", err, 1'b0);
        tick();
        chk("single_strobe", rsp_valid, 4'b0000);
        chk("single_hold", rsp_x, 12'd101);

        // Round-robin with all four requesters
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 12'(16 * (i + 1)), 12'd0, 32'(i));
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("rr_grant%0d", i), req_ready, 4'b0001 << (i % 4));
            tick();
        end
        req_valid = 4'h0;
        wait_rsp(60, n);
        chk("rr_first_lat", n, 28);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("rr_rspv%0d", j), rsp_valid, 4'b0001 << (j % 4));
            chk($sformatf("rr_rx%0d", j), rsp_x, 12'(16 * (j % 4 + 1) + 1));
            tick();
        end

        // Sparse fairness: make requester 1 the last grantee, then 1 and 3 compete
        req_valid = 4'b0010;
        #1;
        chk("sparse_pre", req_ready, 4'b0010);
        tick();
        req_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("sparse_grant%0d", i), req_ready, (i % 2 == 0) ? 4'b1000 : 4'b0010);
            tick();
        end
        req_valid = 4'b0000;
        repeat (40) tick();

        // Enable gating and busy
        en        = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("en_off_ready%0d", i), req_ready, 4'b0000);
            chk($sformatf("en_off_cvin%0d", i), cor_valid_in, 1'b0);
            tick();
        end
        chk("en_off_busy", busy, 1'b0);
        en = 1'b1;
        #1;
        chk("en_on_ready", req_ready, 4'b0100);
        tick();
        en        = 1'b0;
        req_valid = 4'h0;
        chk("en_one_cvin", cor_valid_in, 1'b1);
        chk("en_one_busy", busy, 1'b1);
        tick();
        chk("en_no_second", cor_valid_in, 1'b0);
        n = 1;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        chk("busy_fall", n, 35);
        chk("busy_rspv", rsp_valid, 4'b0100);
        en = 1'b1;
        repeat (3) tick();

        // Latency fault: model answers one cycle early
        tap = 6'd32;
        set_op(0, 12'd200, 12'd5, 32'd7);
        req_valid = 4'b0001;
        #1;
        chk("fault_ready", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0000;
        bad = 1'b0;
        repeat (40) begin
            tick();
            if (rsp_valid != 4'b0000) bad = 1'b1;
        end
        chk("fault_no_rsp", bad, 1'b0);
        chk("fault_err", err, 1'b1);
        repeat (5) tick();
        chk("fault_sticky", err, 1'b1);

        // Stray output: masked during drain window, flagged afterwards
        tap = 6'd33;
        do_reset();
        chk("drain_err_clr", err, 1'b0);
        inj = 1'b1;
        tick();
        inj = 1'b0;
        tick();
        chk("drain_masked", err, 1'b0);
        repeat (40) tick();
        chk("post_drain_clean", err, 1'b0);
        inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("stray_err", err, 1'b1);
        chk("stray_no_rsp", rsp_valid, 4'b0000);

        // Reset while five jobs are in flight
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 12'(i + 1), 12'd0, 32'd0);
        set_op(2, 12'd300, 12'd20, 32'h1234);
        req_valid = 4'hF;
        repeat (5) tick();
        rst_n     = 1'b0;
        req_valid = 4'h0;
        tick();
        tick();
        rst_n = 1'b1;
        bad   = 1'b0;
        repeat (45) begin
            tick();
            if (rsp_valid != 4'b0000) bad = 1'b1;
        end
        chk("mid_no_rsp", bad, 1'b0);
        chk("mid_err", err, 1'b0);
        req_valid = 4'b0101;
        #1;
        chk("mid_last_reset", req_ready, 4'b0001);
        req_valid = 4'b0100;
        #1;
        chk("mid_req2_ready", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0000;
        wait_rsp(60, n);
        chk("mid_lat", n, 35);
        chk("mid_rspv", rsp_valid, 4'b0100);
        chk("mid_rx", rsp_x, 12'd301);
        chk("mid_ry", rsp_y, 12'd19);
        chk("mid_rph", rsp_phase, 32'h1235);
        chk("mid_err_end", err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
